// File: rtl/input_event_capture_pkg.sv
// -----------------------------------------------------------------------------
// input_event_pkg
// Shared definitions for the input event capture block.
//   ch_w()        : channel index width, max(1, clog2(n))
//   evt_w()       : width of one queued event record
//   COALESCE_MAX  : saturation value of the coalesce statistics counter
// Event record layout (MSB..LSB): {coalesced, ts, data, channel}.
// The packed struct itself lives in the users because its field widths
// depend on their parameters.
// -----------------------------------------------------------------------------
package input_event_pkg;

    localparam logic [7:0] COALESCE_MAX = 8'd255;

    function automatic int ch_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int evt_w(input int ch_bits, input int joy_bits, input int ts_bits);
        return 1 + ts_bits + joy_bits + ch_bits;
    endfunction

endpackage

// File: rtl/input_event_capture_if.sv
// -----------------------------------------------------------------------------
// input_event_capture_if
// Bundles the joystick inputs, event FIFO head and statistics of the capture
// block.
//   master : the hps_io / CPU side (drives inputs, pops events)
//   slave  : the capture block
// Signals: joystick, timestamp, enable, evt_pop, clear_stats (to block);
//          evt_valid, evt_channel, evt_data, evt_ts, evt_coalesced,
//          evt_count, coalesce_cnt (from block).
// -----------------------------------------------------------------------------
interface input_event_capture_if
    import input_event_pkg::*;
#(
    parameter int CHANNELS = 6,
    parameter int JOY_W    = 32,
    parameter int TS_W     = 33,
    parameter int DEPTH    = 16
) ();

    localparam int CH_W  = ch_w(CHANNELS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CHANNELS*JOY_W-1:0] joystick;
    logic [TS_W-1:0]           timestamp;
    logic                      enable;
    logic                      evt_valid;
    logic [CH_W-1:0]           evt_channel;
    logic [JOY_W-1:0]          evt_data;
    logic [TS_W-1:0]           evt_ts;
    logic                      evt_coalesced;
    logic                      evt_pop;
    logic [CNT_W-1:0]          evt_count;
    logic [7:0]                coalesce_cnt;
    logic                      clear_stats;

    modport master (
        output joystick, timestamp, enable, evt_pop, clear_stats,
        input  evt_valid, evt_channel, evt_data, evt_ts, evt_coalesced,
               evt_count, coalesce_cnt
    );

    modport slave (
        input  joystick, timestamp, enable, evt_pop, clear_stats,
        output evt_valid, evt_channel, evt_data, evt_ts, evt_coalesced,
               evt_count, coalesce_cnt
    );

endinterface

// File: rtl/input_event_capture_event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous show-ahead FIFO: dout shows the head entry whenever valid=1
// (and reads 0 when empty). A push while full is accepted only together
// with a pop of a valid entry. Pop while empty is ignored.
//   clk_sys, reset : clock, synchronous active-high reset
//   push, din      : write request and data
//   pop            : remove head entry
//   dout, valid    : head entry, FIFO non-empty
//   full, count    : FIFO full, current occupancy
// -----------------------------------------------------------------------------
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign valid     = (r_count != '0);
    assign full      = (r_count == FULL_COUNT);
    assign w_do_pop  = pop && valid;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    // NOTE: storage is deliberately left out of reset; an entry is only ever
    // read after it was written, so resetting it would just cost a mux per bit.
    always_ff @(posedge clk_sys) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/input_event_capture.sv
// -----------------------------------------------------------------------------
// input_event_capture
// Watches CHANNELS joystick words and queues one event per detected change
// into a show-ahead FIFO for the CPU. Each event carries channel index, new
// value, timestamp and a flag telling whether it replaced earlier undelivered
// changes on the same channel.
//   clk_sys : system clock
//   reset   : synchronous, active-high reset
//   bus     : input_event_capture_if.slave
//             inputs  joystick, timestamp, enable, evt_pop, clear_stats
//             outputs evt_valid/channel/data/ts/coalesced, evt_count,
//                     coalesce_cnt
// -----------------------------------------------------------------------------
module input_event_capture
    import input_event_pkg::*;
#(
    parameter int CHANNELS = 6,
    parameter int JOY_W    = 32,
    parameter int TS_W     = 33,
    parameter int DEPTH    = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input_event_capture_if.slave  bus
);

    localparam int CH_W  = ch_w(CHANNELS);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EVT_W = evt_w(CH_W, JOY_W, TS_W);

    typedef struct packed {
        logic             coalesced;
        logic [TS_W-1:0]  ts;
        logic [JOY_W-1:0] data;
        logic [CH_W-1:0]  channel;
    } event_t;

    // Per-channel state
    logic [JOY_W-1:0]    r_last    [CHANNELS];
    logic [JOY_W-1:0]    r_snap    [CHANNELS];
    logic [TS_W-1:0]     r_snap_ts [CHANNELS];
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_coal;
    logic [7:0]          r_coalesce_cnt;

    logic [JOY_W-1:0]    w_joy [CHANNELS];
    logic [CHANNELS-1:0] w_changed;
    logic [CHANNELS-1:0] w_capture;
    logic [CHANNELS-1:0] w_coalesce;
    logic [CHANNELS-1:0] w_grant;
    logic [CH_W-1:0]     w_grant_idx;
    logic                w_grant_en;
    logic [8:0]          w_cnt_sum;

    event_t              w_push_evt;
    event_t              w_head_evt;
    logic                w_fifo_valid;
    logic                w_fifo_full;
    logic [CNT_W-1:0]    w_fifo_count;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_changed = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_joy[i]     = bus.joystick[i*JOY_W +: JOY_W];
            w_changed[i] = (w_joy[i] != r_last[i]);
        end
    end

    assign w_capture = w_changed & {CHANNELS{bus.enable}};

    // Lowest-index pending channel. A full FIFO still accepts the grant when
    // the CPU pops a valid head in the same cycle.
    always_comb begin
        w_grant_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant_idx = CH_W'(i);
            end
        end
    end

    assign w_grant_en = (|r_pending) && (!w_fifo_full || (bus.evt_pop && w_fifo_valid));
    // x & -x isolates the lowest set bit, i.e. the one-hot of w_grant_idx.
    assign w_grant    = w_grant_en ? (r_pending & (~r_pending + CHANNELS'(1))) : '0;

    // A new change on a still-pending channel overwrites the undelivered
    // snapshot. A channel granted in the same cycle has its old snapshot
    // written out, so the new one is a fresh entry rather than a coalesce.
    assign w_coalesce = w_capture & r_pending & ~w_grant;
    assign w_cnt_sum  = {1'b0, r_coalesce_cnt} + 9'($countones(w_coalesce));

    always_comb begin
        w_push_evt.coalesced = r_coal[w_grant_idx];
        w_push_evt.ts        = r_snap_ts[w_grant_idx];
        w_push_evt.data      = r_snap[w_grant_idx];
        w_push_evt.channel   = w_grant_idx;
    end

    // Snapshots are only meaningful while pending is set, so they need no reset.
    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_capture[i]) begin
                r_snap[i]    <= w_joy[i];
                r_snap_ts[i] <= bus.timestamp;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Loading the live inputs prevents a spurious event at release.
            for (int i = 0; i < CHANNELS; i++) begin
                r_last[i] <= w_joy[i];
            end
            r_pending      <= '0;
            r_coal         <= '0;
            r_coalesce_cnt <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_changed[i]) begin
                    r_last[i] <= w_joy[i];
                end
            end
            r_pending <= (r_pending & ~w_grant) | w_capture;
            r_coal    <= (r_coal | w_coalesce) & ~w_grant;
            if (bus.clear_stats) begin
                r_coalesce_cnt <= '0;
            end else if (w_cnt_sum > {1'b0, COALESCE_MAX}) begin
                r_coalesce_cnt <= COALESCE_MAX;
            end else begin
                r_coalesce_cnt <= w_cnt_sum[7:0];
            end
        end
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_event_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (w_grant_en),
        .pop     (bus.evt_pop),
        .din     (w_push_evt),
        .dout    (w_head_evt),
        .valid   (w_fifo_valid),
        .full    (w_fifo_full),
        .count   (w_fifo_count)
    );

    assign bus.evt_valid     = w_fifo_valid;
    assign bus.evt_channel   = w_head_evt.channel;
    assign bus.evt_data      = w_head_evt.data;
    assign bus.evt_ts        = w_head_evt.ts;
    assign bus.evt_coalesced = w_head_evt.coalesced;
    assign bus.evt_count     = w_fifo_count;
    assign bus.coalesce_cnt  = r_coalesce_cnt;

endmodule
